sram_data_responder: RTL

Synchronous SRAM responder serving the CPU-side data SRAM request interface (en / 4-bit byte wen / 32-bit addr / 32-bit wdata in, 32-bit rdata out). It sits on the memory side of the CPU top level in simulation and FPGA builds, as the data-port target for the core.

- Each enabled cycle it performs a byte-masked write and/or a word read, returning read data one cycle later.
- It maps kseg0/kseg1 virtual addresses to physical addresses.
- It flags out-of-range accesses and keeps read/write access counters for debug.

---
 rtl/sram_data_responder.sv | 101 ++++++++++
 1 files changed

// File: rtl/sram_data_responder.sv
// Data-side SRAM responder for the CPU core.
// Maps kseg0/kseg1 addresses to physical, performs byte-masked writes or word
// reads with one cycle of latency (write-first), flags out-of-range accesses
// with a sticky bit, and counts accepted reads and writes for debug.
module sram_data_responder #(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter logic [31:0] OOB_RDATA  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sram_en,
  input  logic [3:0]  sram_wen,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  output logic        oob_err,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [31:0] mem [Depth];

  logic [31:0]           phys;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  in_range;
  logic [31:0]           old_word;
  logic [31:0]           merged_word;
  logic                  mem_we;

  logic [31:0] rdata_q, rdata_d;
  logic        oob_q, oob_d;
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;

  // Segment bits are dropped and lanes are pre-aligned by the core.
  logic unused_addr;
  assign unused_addr = ^{sram_addr[31:29], sram_addr[1:0]};

  assign phys     = {3'b000, sram_addr[28:0]};
  assign idx      = phys[ADDR_WIDTH+1:2];
  assign in_range = ~|phys[31:ADDR_WIDTH+2];
  assign old_word = mem[idx];

  // Byte-lane merge; the same word feeds the array and the rdata register.
  always_comb begin
    merged_word = old_word;
    for (int i = 0; i < 4; i++) begin
      if (sram_wen[i]) merged_word[8*i +: 8] = sram_wdata[8*i +: 8];
    end
  end

  // Request decode and next-state for rdata, sticky error and counters.
  always_comb begin
    rdata_d  = rdata_q;
    oob_d    = oob_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    mem_we   = 1'b0;
    if (sram_en) begin
      if (!in_range) begin
        rdata_d = OOB_RDATA;
        oob_d   = 1'b1;
      end else if (|sram_wen) begin
        mem_we   = 1'b1;
        rdata_d  = merged_word;
        wr_cnt_d = wr_cnt_q + 32'd1;
      end else begin
        rdata_d  = old_word;
        rd_cnt_d = rd_cnt_q + 32'd1;
      end
    end
  end

  // Array write port; contents survive reset, and reset suppresses writes.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem[idx] <= merged_word;
  end

  // Output and debug state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q  <= 32'h0;
      oob_q    <= 1'b0;
      rd_cnt_q <= 32'h0;
      wr_cnt_q <= 32'h0;
    end else begin
      rdata_q  <= rdata_d;
      oob_q    <= oob_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign sram_rdata = rdata_q;
  assign oob_err    = oob_q;
  assign rd_count   = rd_cnt_q;
  assign wr_count   = wr_cnt_q;

endmodule
